// File: rtl/axi_region_remap_pkg.sv
// Shared types for the AXI region remapper: response codes, error-slave FSM
// states and the window decode function.
package axi_remap_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Decode works on the widest supported address so one function serves every
  // parameterisation; callers zero-extend addresses and window tables.
  localparam int MAX_AW      = 64;
  localparam int MAX_REGIONS = 8;

  typedef enum logic [1:0] {
    WIDLE  = 2'd0,
    WDRAIN = 2'd1,
    WRESP  = 2'd2
  } wr_state_e;

  typedef enum logic {
    RIDLE = 1'b0,
    RERR  = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } decode_t;

  // Window end is formed one bit wider than the address so a window touching
  // the top of the address space does not wrap. Lowest index wins on overlap.
  function automatic decode_t region_decode(
    input logic [MAX_AW-1:0]             addr,
    input logic [MAX_REGIONS*MAX_AW-1:0] base,
    input logic [MAX_REGIONS*MAX_AW-1:0] size,
    input int                            num_regions
  );
    decode_t       d;
    logic [MAX_AW:0] a;
    logic [MAX_AW:0] lo;
    logic [MAX_AW:0] hi;
    d = '0;
    a = {1'b0, addr};
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      lo = {1'b0, base[i*MAX_AW +: MAX_AW]};
      hi = lo + {1'b0, size[i*MAX_AW +: MAX_AW]};
      if (i < num_regions && a >= lo && a < hi) begin
        d.hit = 1'b1;
        d.idx = 3'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_region_remap_if.sv
// AXI4 bundle (AW/W/B/AR/R) with atop on AW; master drives requests, slave
// drives responses.
interface axi_region_remap_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [5:0]          awatop;
  logic [3:0]          awregion;
  logic [USER_W-1:0]   awuser;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic [USER_W-1:0]   buser;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [USER_W-1:0]   aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [USER_W-1:0]   ruser;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awatop, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
           awatop, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
           arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_region_remap_err_slv.sv
// Internal DECERR slave: swallows a missed write burst and answers with one B,
// or streams arlen+1 error beats for a missed read.
module axi_remap_err_slv
  import axi_remap_pkg::*;
#(
  parameter int ID_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            aw_go,
  input  logic [ID_W-1:0] aw_id,
  input  logic            w_valid,
  input  logic            w_last,
  output logic            w_ready,
  output logic            b_valid,
  input  logic            b_ready,
  output logic [ID_W-1:0] b_id,
  input  logic            ar_go,
  input  logic [ID_W-1:0] ar_id,
  input  logic [7:0]      ar_len,
  output logic            r_valid,
  input  logic            r_ready,
  output logic            r_last,
  output logic [ID_W-1:0] r_id,
  output wr_state_e       wr_state,
  output rd_state_e       rd_state
);

  wr_state_e       wr_q, wr_d;
  rd_state_e       rd_q, rd_d;
  logic [ID_W-1:0] bid_q;
  logic [ID_W-1:0] rid_q;
  logic [7:0]      rlen_q;
  logic [7:0]      beat_q, beat_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= WIDLE;
      rd_q   <= RIDLE;
      beat_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      beat_q <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_q == WIDLE && aw_go) bid_q <= aw_id;
    if (rd_q == RIDLE && ar_go) begin
      rid_q  <= ar_id;
      rlen_q <= ar_len;
    end
  end

  always_comb begin
    wr_d    = wr_q;
    w_ready = 1'b0;
    b_valid = 1'b0;
    case (wr_q)
      WIDLE:  if (aw_go) wr_d = WDRAIN;
      WDRAIN: begin
        w_ready = 1'b1;
        if (w_valid && w_last) wr_d = WRESP;
      end
      WRESP: begin
        b_valid = 1'b1;
        if (b_ready) wr_d = WIDLE;
      end
      default: wr_d = WIDLE;
    endcase
  end

  // Beat index only moves on an accepted beat so a stalled master sees stable data.
  always_comb begin
    rd_d    = rd_q;
    beat_d  = beat_q;
    r_valid = 1'b0;
    r_last  = 1'b0;
    case (rd_q)
      RIDLE: if (ar_go) begin
        rd_d   = RERR;
        beat_d = '0;
      end
      RERR: begin
        r_valid = 1'b1;
        r_last  = (beat_q == rlen_q);
        if (r_ready) begin
          if (r_last) begin
            rd_d   = RIDLE;
            beat_d = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: rd_d = RIDLE;
    endcase
  end

  assign b_id     = bid_q;
  assign r_id     = rid_q;
  assign wr_state = wr_q;
  assign rd_state = rd_q;

endmodule

// File: rtl/axi_region_remap.sv
// AXI4 window remapper: relocates up to NUM_REGIONS address windows, answers
// misses with DECERR. Define AXI_REGION_REMAP_REG_EN to register AW/AR after decode.
// Handshakes: a beat moves on a rising edge where valid && ready; valid never
// waits for ready, and every valid/ready output is held low while aresetn is low.
module axi_region_remap
  import axi_remap_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int AXI_USER_WIDTH  = 1,
  parameter int NUM_REGIONS     = 2,
  parameter logic [NUM_REGIONS*AXI_ADDR_WIDTH-1:0] REGION_BASE   = {32'h1000_0000, 32'h8000_0000},
  parameter logic [NUM_REGIONS*AXI_ADDR_WIDTH-1:0] REGION_SIZE   = {32'h0000_1000, 32'h4000_0000},
  parameter logic [NUM_REGIONS*AXI_ADDR_WIDTH-1:0] REGION_TARGET = {32'h4000_0000, 32'h0000_0000},
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_region_remap_if.slave    s_axi,
  axi_region_remap_if.master   m_axi,
  output wr_state_e            dbg_wr_state,
  output rd_state_e            dbg_rd_state,
  output logic [CNT_W-1:0]     dbg_wr_cnt,
  output logic [CNT_W-1:0]     dbg_rd_cnt
);

  localparam int AW      = AXI_ADDR_WIDTH;
  localparam int IW      = AXI_ID_WIDTH;
  localparam int UW      = AXI_USER_WIDTH;
  localparam int AR_PL_W = IW + AW + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + UW;
  localparam int AW_PL_W = AR_PL_W + 6;

  logic [MAX_REGIONS*MAX_AW-1:0] base_ext, size_ext;
  decode_t aw_dec, ar_dec;
  logic [AW-1:0] aw_xaddr, ar_xaddr;

  always_comb begin
    base_ext = '0;
    size_ext = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_ext[i*MAX_AW +: MAX_AW] = MAX_AW'(REGION_BASE[i*AW +: AW]);
      size_ext[i*MAX_AW +: MAX_AW] = MAX_AW'(REGION_SIZE[i*AW +: AW]);
    end
  end

  assign aw_dec = region_decode(MAX_AW'(s_axi.awaddr), base_ext, size_ext, NUM_REGIONS);
  assign ar_dec = region_decode(MAX_AW'(s_axi.araddr), base_ext, size_ext, NUM_REGIONS);

  // Relocation is modulo 2^AW; on a miss the result is unused.
  assign aw_xaddr = s_axi.awaddr - REGION_BASE[int'(aw_dec.idx)*AW +: AW]
                  + REGION_TARGET[int'(aw_dec.idx)*AW +: AW];
  assign ar_xaddr = s_axi.araddr - REGION_BASE[int'(ar_dec.idx)*AW +: AW]
                  + REGION_TARGET[int'(ar_dec.idx)*AW +: AW];

  logic [AW_PL_W-1:0] s_aw_pl, a_aw_pl;
  logic [AR_PL_W-1:0] s_ar_pl, a_ar_pl;
  logic a_awvalid, a_awready, a_aw_hit, s_awready_int;
  logic a_arvalid, a_arready, a_ar_hit, s_arready_int;

  assign s_aw_pl = {s_axi.awid, aw_xaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                    s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                    s_axi.awatop, s_axi.awregion, s_axi.awuser};
  assign s_ar_pl = {s_axi.arid, ar_xaddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                    s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                    s_axi.arregion, s_axi.aruser};

`ifdef AXI_REGION_REMAP_REG_EN
  // Pipeline slice: reloads whenever empty or draining, so no bubble between bursts.
  logic aw_q_valid, aw_q_hit, ar_q_valid, ar_q_hit;
  logic [AW_PL_W-1:0] aw_q_pl;
  logic [AR_PL_W-1:0] ar_q_pl;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_q_valid <= 1'b0;
      ar_q_valid <= 1'b0;
    end else begin
      if (s_awready_int) aw_q_valid <= s_axi.awvalid;
      if (s_arready_int) ar_q_valid <= s_axi.arvalid;
    end
  end

  always_ff @(posedge aclk) begin
    if (s_awready_int) begin
      aw_q_pl  <= s_aw_pl;
      aw_q_hit <= aw_dec.hit;
    end
    if (s_arready_int) begin
      ar_q_pl  <= s_ar_pl;
      ar_q_hit <= ar_dec.hit;
    end
  end

  assign s_awready_int = !aw_q_valid || a_awready;
  assign s_arready_int = !ar_q_valid || a_arready;
  assign a_awvalid     = aw_q_valid;
  assign a_aw_pl       = aw_q_pl;
  assign a_aw_hit      = aw_q_hit;
  assign a_arvalid     = ar_q_valid;
  assign a_ar_pl       = ar_q_pl;
  assign a_ar_hit      = ar_q_hit;
`else
  assign s_awready_int = a_awready;
  assign s_arready_int = a_arready;
  assign a_awvalid     = s_axi.awvalid;
  assign a_aw_pl       = s_aw_pl;
  assign a_aw_hit      = aw_dec.hit;
  assign a_arvalid     = s_axi.arvalid;
  assign a_ar_pl       = s_ar_pl;
  assign a_ar_hit      = ar_dec.hit;
`endif

  assign s_axi.awready = aresetn && s_awready_int;
  assign s_axi.arready = aresetn && s_arready_int;

  logic [IW-1:0] a_awid, a_arid;
  logic [7:0]    a_arlen;
  assign a_awid  = a_aw_pl[AW_PL_W-1 -: IW];
  assign a_arid  = a_ar_pl[AR_PL_W-1 -: IW];
  assign a_arlen = a_ar_pl[AR_PL_W-IW-AW-1 -: 8];

  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
          m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awatop,
          m_axi.awregion, m_axi.awuser} = a_aw_pl;
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
          m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos,
          m_axi.arregion, m_axi.aruser} = a_ar_pl;

  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic w_pend, w_to_err;
  logic wr_full, rd_full, wr_inc, wr_dec, rd_inc, rd_dec;
  logic err_wready, err_bvalid, err_rvalid, err_rlast;
  logic [IW-1:0] err_bid, err_rid;
  wr_state_e wr_state;
  rd_state_e rd_state;
  logic err_w_idle, err_r_idle, aw_go, ar_go, s_w_hs;

  assign wr_full    = (wr_cnt == CNT_W'(MAX_OUTSTANDING));
  assign rd_full    = (rd_cnt == CNT_W'(MAX_OUTSTANDING));
  assign err_w_idle = (wr_state == WIDLE);
  assign err_r_idle = (rd_state == RIDLE);

  // A miss waits for the downstream side to go quiet so responses never interleave.
  assign a_awready = aresetn && !w_pend &&
                     (a_aw_hit ? (m_axi.awready && !wr_full) : (wr_cnt == '0 && err_w_idle));
  assign a_arready = aresetn &&
                     (a_ar_hit ? (m_axi.arready && !rd_full) : (rd_cnt == '0 && err_r_idle));
  assign m_axi.awvalid = aresetn && a_awvalid && a_aw_hit && !w_pend && !wr_full;
  assign m_axi.arvalid = aresetn && a_arvalid && a_ar_hit && !rd_full;
  assign aw_go = a_awvalid && a_awready && !a_aw_hit;
  assign ar_go = a_arvalid && a_arready && !a_ar_hit;

  assign m_axi.wdata  = s_axi.wdata;
  assign m_axi.wstrb  = s_axi.wstrb;
  assign m_axi.wlast  = s_axi.wlast;
  assign m_axi.wuser  = s_axi.wuser;
  assign m_axi.wvalid = aresetn && w_pend && !w_to_err && s_axi.wvalid;
  assign s_axi.wready = aresetn && w_pend && (w_to_err ? err_wready : m_axi.wready);
  assign s_w_hs       = s_axi.wvalid && s_axi.wready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_pend   <= 1'b0;
      w_to_err <= 1'b0;
    end else if (a_awvalid && a_awready) begin
      w_pend   <= 1'b1;
      w_to_err <= !a_aw_hit;
    end else if (s_w_hs && s_axi.wlast) begin
      w_pend   <= 1'b0;
    end
  end

  assign s_axi.bvalid = aresetn && (err_w_idle ? m_axi.bvalid : err_bvalid);
  assign s_axi.bid    = err_w_idle ? m_axi.bid   : err_bid;
  assign s_axi.bresp  = err_w_idle ? m_axi.bresp : RESP_DECERR;
  assign s_axi.buser  = err_w_idle ? m_axi.buser : '0;
  assign m_axi.bready = aresetn && err_w_idle && s_axi.bready;

  assign s_axi.rvalid = aresetn && (err_r_idle ? m_axi.rvalid : err_rvalid);
  assign s_axi.rid    = err_r_idle ? m_axi.rid   : err_rid;
  assign s_axi.rdata  = err_r_idle ? m_axi.rdata : '0;
  assign s_axi.rresp  = err_r_idle ? m_axi.rresp : RESP_DECERR;
  assign s_axi.rlast  = err_r_idle ? m_axi.rlast : err_rlast;
  assign s_axi.ruser  = err_r_idle ? m_axi.ruser : '0;
  assign m_axi.rready = aresetn && err_r_idle && s_axi.rready;

  assign wr_inc = m_axi.awvalid && m_axi.awready;
  assign wr_dec = m_axi.bvalid && m_axi.bready;
  assign rd_inc = m_axi.arvalid && m_axi.arready;
  assign rd_dec = m_axi.rvalid && m_axi.rready && m_axi.rlast;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_inc && !wr_dec) wr_cnt <= wr_cnt + CNT_W'(1);
      else if (!wr_inc && wr_dec) wr_cnt <= wr_cnt - CNT_W'(1);
      if (rd_inc && !rd_dec) rd_cnt <= rd_cnt + CNT_W'(1);
      else if (!rd_inc && rd_dec) rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  axi_remap_err_slv #(.ID_W(IW)) u_err (
    .clk      (aclk),
    .rst_n    (aresetn),
    .aw_go    (aw_go),
    .aw_id    (a_awid),
    .w_valid  (s_axi.wvalid && w_pend && w_to_err),
    .w_last   (s_axi.wlast),
    .w_ready  (err_wready),
    .b_valid  (err_bvalid),
    .b_ready  (s_axi.bready),
    .b_id     (err_bid),
    .ar_go    (ar_go),
    .ar_id    (a_arid),
    .ar_len   (a_arlen),
    .r_valid  (err_rvalid),
    .r_ready  (s_axi.rready),
    .r_last   (err_rlast),
    .r_id     (err_rid),
    .wr_state (wr_state),
    .rd_state (rd_state)
  );

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;
  assign dbg_wr_cnt   = wr_cnt;
  assign dbg_rd_cnt   = rd_cnt;

endmodule

// File: tb/tb_axi_region_remap.sv
// Directed bench for axi_region_remap (default build): the bench plays both the
// upstream master and the downstream slave and checks against hand-computed values.
module tb_axi_region_remap;
  import axi_remap_pkg::*;

  logic aclk;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;

  wr_state_e  dbg_wr_state;
  rd_state_e  dbg_rd_state;
  logic [3:0] dbg_wr_cnt;
  logic [3:0] dbg_rd_cnt;

  axi_region_remap_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6), .USER_W(1)) s_bus ();
  axi_region_remap_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6), .USER_W(1)) m_bus ();

  axi_region_remap dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axi        (s_bus),
    .m_axi        (m_bus),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state),
    .dbg_wr_cnt   (dbg_wr_cnt),
    .dbg_rd_cnt   (dbg_rd_cnt)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id);
    s_bus.awaddr  = addr;
    s_bus.awlen   = len;
    s_bus.awid    = id;
    s_bus.awvalid = 1'b1;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id);
    s_bus.araddr  = addr;
    s_bus.arlen   = len;
    s_bus.arid    = id;
    s_bus.arvalid = 1'b1;
  endtask

  task automatic clear_inputs();
    s_bus.awid = '0; s_bus.awaddr = '0; s_bus.awlen = '0; s_bus.awsize = 3'd3;
    s_bus.awburst = 2'b01; s_bus.awlock = 1'b0; s_bus.awcache = '0; s_bus.awprot = '0;
    s_bus.awqos = '0; s_bus.awatop = '0; s_bus.awregion = '0; s_bus.awuser = '0;
    s_bus.awvalid = 1'b0;
    s_bus.wdata = '0; s_bus.wstrb = '1; s_bus.wlast = 1'b0; s_bus.wuser = '0;
    s_bus.wvalid = 1'b0; s_bus.bready = 1'b0;
    s_bus.arid = '0; s_bus.araddr = '0; s_bus.arlen = '0; s_bus.arsize = 3'd3;
    s_bus.arburst = 2'b01; s_bus.arlock = 1'b0; s_bus.arcache = '0; s_bus.arprot = '0;
    s_bus.arqos = '0; s_bus.arregion = '0; s_bus.aruser = '0; s_bus.arvalid = 1'b0;
    s_bus.rready = 1'b0;
    m_bus.awready = 1'b0; m_bus.wready = 1'b0; m_bus.arready = 1'b0;
    m_bus.bid = '0; m_bus.bresp = '0; m_bus.buser = '0; m_bus.bvalid = 1'b0;
    m_bus.rid = '0; m_bus.rdata = '0; m_bus.rresp = '0; m_bus.rlast = 1'b0;
    m_bus.ruser = '0; m_bus.rvalid = 1'b0;
  endtask

  int n_acc;
  int beat;

  initial begin
    clear_inputs();
    aresetn = 1'b0;

    // reset: handshake outputs low even with requests and readies pending
    drive_aw(32'h8000_0000, 8'd0, 6'd0);
    m_bus.awready = 1'b1;
    s_bus.rready  = 1'b1;
    tick(); tick();
    check("rst_awready", s_bus.awready, 1'b0);
    check("rst_m_awvalid", m_bus.awvalid, 1'b0);
    check("rst_m_rready", m_bus.rready, 1'b0);
    check("rst_wr_state", dbg_wr_state, WIDLE);
    check("rst_rd_cnt", dbg_rd_cnt, 4'd0);
    clear_inputs();
    aresetn = 1'b1;
    tick();

    // 1: write hit, 4 beats forwarded, OKAY back
    drive_aw(32'h8000_0100, 8'd3, 6'd3);
    m_bus.awready = 1'b1;
    #1;
    check("t1_m_awvalid", m_bus.awvalid, 1'b1);
    check("t1_m_awaddr", m_bus.awaddr, 32'h0000_0100);
    check("t1_m_awlen", m_bus.awlen, 8'd3);
    check("t1_s_awready", s_bus.awready, 1'b1);
    tick();
    s_bus.awvalid = 1'b0;
    check("t1_wr_cnt", dbg_wr_cnt, 4'd1);
    m_bus.wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_bus.wvalid = 1'b1;
      s_bus.wdata  = 64'hA5A5_0000_0000_0000 + 64'(i);
      s_bus.wlast  = (i == 3);
      #1;
      check("t1_m_wvalid", m_bus.wvalid, 1'b1);
      check("t1_m_wdata", m_bus.wdata, 64'hA5A5_0000_0000_0000 + 64'(i));
      check("t1_m_wlast", m_bus.wlast, (i == 3));
      tick();
    end
    s_bus.wvalid = 1'b0;
    s_bus.wlast  = 1'b0;
    m_bus.bvalid = 1'b1; m_bus.bid = 6'd3; m_bus.bresp = RESP_OKAY;
    s_bus.bready = 1'b1;
    #1;
    check("t1_s_bvalid", s_bus.bvalid, 1'b1);
    check("t1_s_bresp", s_bus.bresp, RESP_OKAY);
    check("t1_s_bid", s_bus.bid, 6'd3);
    tick();
    m_bus.bvalid = 1'b0;
    s_bus.bready = 1'b0;
    check("t1_wr_cnt_done", dbg_wr_cnt, 4'd0);

    // 2: read hit at top of small window, then first address past it
    drive_ar(32'h1000_0FF8, 8'd0, 6'd1);
    m_bus.arready = 1'b1;
    #1;
    check("t2_m_arvalid", m_bus.arvalid, 1'b1);
    check("t2_m_araddr", m_bus.araddr, 32'h4000_0FF8);
    tick();
    s_bus.arvalid = 1'b0;
    m_bus.rvalid = 1'b1; m_bus.rlast = 1'b1; m_bus.rid = 6'd1; m_bus.rdata = 64'h55;
    s_bus.rready = 1'b1;
    #1;
    check("t2_s_rdata", s_bus.rdata, 64'h55);
    check("t2_s_rresp", s_bus.rresp, RESP_OKAY);
    tick();
    m_bus.rvalid = 1'b0;
    m_bus.rlast  = 1'b0;
    drive_ar(32'h1000_1000, 8'd0, 6'd2);
    #1;
    check("t2_miss_m_arvalid", m_bus.arvalid, 1'b0);
    check("t2_miss_arready", s_bus.arready, 1'b1);
    tick();
    s_bus.arvalid = 1'b0;
    check("t2_rd_state", dbg_rd_state, RERR);
    check("t2_err_rvalid", s_bus.rvalid, 1'b1);
    check("t2_err_rresp", s_bus.rresp, RESP_DECERR);
    check("t2_err_rid", s_bus.rid, 6'd2);
    check("t2_err_rlast", s_bus.rlast, 1'b1);
    tick();
    check("t2_rd_idle", dbg_rd_state, RIDLE);
    s_bus.rready = 1'b0;

    // 3: read miss, 8 beats with rready toggling
    drive_ar(32'h0000_0000, 8'd7, 6'd5);
    tick();
    s_bus.arvalid = 1'b0;
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      s_bus.rready = c[0];
      #1;
      if (c == 0) check("t3_m_rready", m_bus.rready, 1'b0);
      if (s_bus.rvalid && s_bus.rready) begin
        check("t3_rresp", s_bus.rresp, RESP_DECERR);
        check("t3_rid", s_bus.rid, 6'd5);
        check("t3_rdata", s_bus.rdata, 64'h0);
        check("t3_rlast", s_bus.rlast, (beat == 7));
        beat++;
      end
      tick();
    end
    s_bus.rready = 1'b0;
    check("t3_beats", 64'(beat), 64'd8);
    check("t3_rd_idle", dbg_rd_state, RIDLE);

    // 4: write miss waits for two outstanding hits to complete
    m_bus.awready = 1'b1;
    m_bus.wready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_aw(32'h8000_0000 + 32'(i * 64), 8'd0, 6'(i + 1));
      tick();
      s_bus.awvalid = 1'b0;
      s_bus.wvalid = 1'b1; s_bus.wlast = 1'b1;
      tick();
      s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0;
    end
    check("t4_wr_cnt", dbg_wr_cnt, 4'd2);
    drive_aw(32'h0000_0010, 8'd0, 6'd9);
    #1;
    check("t4_awready_blk2", s_bus.awready, 1'b0);
    check("t4_miss_m_awvalid", m_bus.awvalid, 1'b0);
    m_bus.bvalid = 1'b1; m_bus.bid = 6'd1; m_bus.bresp = RESP_OKAY;
    s_bus.bready = 1'b1;
    tick();
    m_bus.bid = 6'd2;
    #1;
    check("t4_awready_blk1", s_bus.awready, 1'b0);
    tick();
    m_bus.bvalid = 1'b0;
    s_bus.bready = 1'b0;
    #1;
    check("t4_awready_free", s_bus.awready, 1'b1);
    tick();
    s_bus.awvalid = 1'b0;
    check("t4_wr_state_drain", dbg_wr_state, WDRAIN);
    s_bus.wvalid = 1'b1; s_bus.wlast = 1'b1;
    #1;
    check("t4_err_wready", s_bus.wready, 1'b1);
    check("t4_m_wvalid", m_bus.wvalid, 1'b0);
    tick();
    s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0;
    s_bus.bready = 1'b1;
    #1;
    check("t4_wr_state_resp", dbg_wr_state, WRESP);
    check("t4_err_bvalid", s_bus.bvalid, 1'b1);
    check("t4_err_bresp", s_bus.bresp, RESP_DECERR);
    check("t4_err_bid", s_bus.bid, 6'd9);
    check("t4_m_bready", m_bus.bready, 1'b0);
    tick();
    s_bus.bready = 1'b0;
    check("t4_wr_idle", dbg_wr_state, WIDLE);

    // 5: nine back-to-back read hits against a silent slave
    m_bus.arready = 1'b1;
    drive_ar(32'h8000_1000, 8'd0, 6'd7);
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (s_bus.arready) n_acc++;
      tick();
    end
    check("t5_accepted", 64'(n_acc), 64'd8);
    check("t5_rd_cnt_full", dbg_rd_cnt, 4'd8);
    check("t5_arready_stall", s_bus.arready, 1'b0);
    m_bus.rvalid = 1'b1; m_bus.rlast = 1'b1; m_bus.rid = 6'd7;
    s_bus.rready = 1'b1;
    tick();
    m_bus.rvalid = 1'b0;
    #1;
    check("t5_arready_slot", s_bus.arready, 1'b1);
    tick();
    s_bus.arvalid = 1'b0;
    check("t5_rd_cnt_refill", dbg_rd_cnt, 4'd8);
    m_bus.rvalid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0;
    s_bus.rready = 1'b0;
    check("t5_rd_cnt_drained", dbg_rd_cnt, 4'd0);

    // 6: reset in the middle of an error read burst
    drive_ar(32'h0000_0100, 8'd7, 6'd6);
    tick();
    s_bus.arvalid = 1'b0;
    s_bus.rready  = 1'b1;
    tick(); tick(); tick();
    check("t6_rvalid_beat3", s_bus.rvalid, 1'b1);
    aresetn = 1'b0;
    tick();
    check("t6_rvalid_rst", s_bus.rvalid, 1'b0);
    check("t6_rd_state", dbg_rd_state, RIDLE);
    check("t6_rd_cnt", dbg_rd_cnt, 4'd0);
    check("t6_wr_cnt", dbg_wr_cnt, 4'd0);
    aresetn = 1'b1;
    tick();
    check("t6_rvalid_after", s_bus.rvalid, 1'b0);
    s_bus.rready = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
